leaf_stream_packer: RTL and testbench
=====================================

Name: leaf_stream_packer

Overview:
Transmit-side packer for a BFT leaf. It accepts NUM_OUT_PORTS user valid/ack streams (the kernel outputs) and emits one 49-bit BFT data packet per cycle onto dout_leaf_interface2bft. It selects among ready ports round-robin, stamps each packet with destination and sequence address, and enforces per-port credit flow control using credit returns decoded from the BFT receive side.

Parameters:
PACKET_BITS, 49, BFT packet width; must equal 1+NUM_LEAF_BITS+NUM_PORT_BITS+1+NUM_ADDR_BITS+PAYLOAD_BITS.
PAYLOAD_BITS, 32, user data width per port.
NUM_LEAF_BITS, 4, destination leaf field width.
NUM_PORT_BITS, 4, destination/local port field width.
NUM_ADDR_BITS, 7, sequence address width; credit counter width is NUM_ADDR_BITS+1.
NUM_OUT_PORTS, 2, number of user output streams (1..2^NUM_PORT_BITS).
INIT_CREDITS, 64, per-port credit reset value (receiver free space).

Ports:
clk  in  1  single clock.
reset  in  1  asynchronous, active-high reset.
din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  user data; port i occupies slice i.
vld_user2interface  in  NUM_OUT_PORTS  user valid per port.
ack_interface2user  out  NUM_OUT_PORTS  accept strobe per port; transfer occurs when vld&ack.
cfg_wr_en  in  1  destination table write.
cfg_port  in  NUM_PORT_BITS  local port index written.
cfg_dst_leaf  in  NUM_LEAF_BITS  destination leaf.
cfg_dst_port  in  NUM_PORT_BITS  destination port.
credit_vld  in  1  credit return strobe.
credit_port  in  NUM_PORT_BITS  local port receiving credit.
credit_amount  in  NUM_ADDR_BITS+1  credits returned.
bft_stall  in  1  BFT cannot take a packet this cycle.
dout_leaf_interface2bft  out  PACKET_BITS  registered packet.
credit_err  out  1  sticky: credit counter saturated or credit to invalid port.

Behaviour:
- Packet layout, MSB to LSB: {valid(1), dst_leaf, dst_port, type(1)=1 for data, addr, payload}. Idle word is all zeros.
- Reset (async): dout = 0, ack = 0, credit_err = 0, credits = INIT_CREDITS, addr counters = 0, table entries invalid, RR pointer = 0.
- Port i is eligible when vld[i] is high, its table entry is valid, and credit[i] > 0.
- When bft_stall = 0, the arbiter grants the first eligible port at or after the RR pointer, wrapping. ack[i] = grant[i], combinational from vld, registered state and bft_stall. ack never depends on itself. At most one ack bit is high.
- Latency is 1 cycle. A packet granted in cycle t appears on dout in cycle t+1 with valid=1. In that grant cycle: addr[i] increments (wraps from 2^NUM_ADDR_BITS-1 to 0), credit[i] decrements, and the RR pointer moves to (i+1) mod NUM_OUT_PORTS.
- If bft_stall = 0 and no port is granted: dout = 0 on the next cycle.
- If bft_stall = 1: ack = 0 and dout holds its value; a held packet is not re-counted.
- Credit update uses credit_port. When a consume and a return hit the same port in the same cycle: credit = credit - 1 + amount. The result saturates at 2^(NUM_ADDR_BITS+1)-1; saturation sets credit_err.
- A credit return to a port >= NUM_OUT_PORTS is dropped and sets credit_err.
- cfg_wr_en writes the table entry and marks it valid from the next cycle; the same-cycle grant uses the old entry. Writes to cfg_port >= NUM_OUT_PORTS are ignored.
- Reset asserted mid-transfer drops any in-flight word; there is no partial packet.

Decomposition:
- Shared package leaf_pkt_pkg holds: field offset/width localparams (VALID_BIT, LEAF_MSB/LSB, PORT_MSB/LSB, TYPE_BIT, ADDR_MSB/LSB), TYPE_DATA/TYPE_CREDIT codes, and a function that builds a packet from its fields.
- One sub-module, leaf_rr_arbiter: parameterised N-way round-robin with request, pointer and one-hot grant; purely combinational, with the pointer kept in the parent.

Test Plan:
- Reset, then cfg port0 -> leaf 3 port 1, with vld0=1 and data 0xDEADBEEF -> ack0 is high the same cycle; next cycle dout = {1,4'h3,4'h1,1,7'd0,32'hDEADBEEF}; addr0 becomes 1.
- Both ports configured, vld=2'b11 held for 4 cycles -> acks alternate 01,10,01,10; dout shows ports 0,1,0,1.
- INIT_CREDITS=64, port0 streams 64 words with no returns -> the 65th cycle has ack0=0 and dout=0; credit_vld with port 0, amount 1 -> next word is accepted.
- Stream 130 words with credits replenished -> the addr field wraps 127 -> 0 at the 129th packet.
- bft_stall=1 for 3 cycles with a packet on dout -> dout is held unchanged, ack=0, credit is not decremented; traffic resumes in order after the stall.
- Consume and credit return (amount 5) on port0 in the same cycle from 10 -> credit reads 14; a return to port 7 -> credit_err=1 and stays high until reset.

Source files
------------

// File: rtl/leaf_pkt_pkg.sv
// Shared BFT packet layout: field widths, bit offsets, type codes and a packet builder.
package leaf_pkt_pkg;

  localparam int unsigned PAYLOAD_BITS  = 32;
  localparam int unsigned NUM_LEAF_BITS = 4;
  localparam int unsigned NUM_PORT_BITS = 4;
  localparam int unsigned NUM_ADDR_BITS = 7;
  localparam int unsigned CREDIT_BITS   = NUM_ADDR_BITS + 1;
  localparam int unsigned PACKET_BITS   =
    1 + NUM_LEAF_BITS + NUM_PORT_BITS + 1 + NUM_ADDR_BITS + PAYLOAD_BITS;

  // Field offsets, LSB upward: payload, addr, type, port, leaf, valid
  localparam int unsigned ADDR_LSB  = PAYLOAD_BITS;
  localparam int unsigned ADDR_MSB  = ADDR_LSB + NUM_ADDR_BITS - 1;
  localparam int unsigned TYPE_BIT  = ADDR_MSB + 1;
  localparam int unsigned PORT_LSB  = TYPE_BIT + 1;
  localparam int unsigned PORT_MSB  = PORT_LSB + NUM_PORT_BITS - 1;
  localparam int unsigned LEAF_LSB  = PORT_MSB + 1;
  localparam int unsigned LEAF_MSB  = LEAF_LSB + NUM_LEAF_BITS - 1;
  localparam int unsigned VALID_BIT = LEAF_MSB + 1;

  localparam logic TYPE_DATA   = 1'b1;
  localparam logic TYPE_CREDIT = 1'b0;

  // Assemble a packet word from its fields
  function automatic logic [PACKET_BITS-1:0] build_packet(
    input logic                     valid,
    input logic [NUM_LEAF_BITS-1:0] leaf,
    input logic [NUM_PORT_BITS-1:0] port,
    input logic                     pkt_type,
    input logic [NUM_ADDR_BITS-1:0] addr,
    input logic [PAYLOAD_BITS-1:0]  payload
  );
    logic [PACKET_BITS-1:0] pkt;
    pkt                     = '0;
    pkt[VALID_BIT]          = valid;
    pkt[LEAF_MSB:LEAF_LSB]  = leaf;
    pkt[PORT_MSB:PORT_LSB]  = port;
    pkt[TYPE_BIT]           = pkt_type;
    pkt[ADDR_MSB:ADDR_LSB]  = addr;
    pkt[PAYLOAD_BITS-1:0]   = payload;
    return pkt;
  endfunction

endpackage

// File: rtl/leaf_rr_arbiter.sv
// Combinational N-way round-robin arbiter: grants the first request at or after ptr.
module leaf_rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic          found;
  logic [PW:0]   pos;
  logic [PW-1:0] idx;

  // Scan requests starting from ptr, wrapping at N
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    idx   = '0;
    for (int k = 0; k < int'(N); k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(N)) begin
        pos = pos - (PW+1)'(N);
      end
      idx = pos[PW-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/leaf_stream_packer.sv
// BFT leaf transmit packer: round-robin over user streams, stamps dst/addr, credit flow control.
module leaf_stream_packer
  import leaf_pkt_pkg::*;
#(
  parameter int unsigned NUM_OUT_PORTS = 2,
  parameter int unsigned INIT_CREDITS  = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  input  logic                                  cfg_wr_en,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_dst_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dst_port,
  input  logic                                  credit_vld,
  input  logic [NUM_PORT_BITS-1:0]              credit_port,
  input  logic [CREDIT_BITS-1:0]                credit_amount,
  input  logic                                  bft_stall,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
  output logic                                  credit_err
);

  localparam int unsigned N  = NUM_OUT_PORTS;
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CREDIT_BITS:0] CREDIT_MAX = {1'b0, {CREDIT_BITS{1'b1}}};

  logic [N-1:0]             tbl_vld;
  logic [NUM_LEAF_BITS-1:0] tbl_leaf [N];
  logic [NUM_PORT_BITS-1:0] tbl_port [N];
  logic [CREDIT_BITS-1:0]   credit     [N];
  logic [CREDIT_BITS-1:0]   credit_nxt [N];
  logic [NUM_ADDR_BITS-1:0] addr [N];
  logic [PAYLOAD_BITS-1:0]  data [N];
  logic [PW-1:0]            rr_ptr;
  logic [PW-1:0]            sel;
  logic [N-1:0]             req;
  logic [N-1:0]             grant;
  logic                     any_grant;
  logic [N-1:0]             sat;
  logic                     bad_return;
  logic [CREDIT_BITS:0]     sum;

  // Unpack user payloads and build eligibility requests (nothing requests while stalled)
  always_comb begin
    req = '0;
    for (int i = 0; i < int'(N); i++) begin
      data[i] = din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      req[i]  = !bft_stall && vld_user2interface[i] && tbl_vld[i] && (credit[i] != '0);
    end
  end

  leaf_rr_arbiter #(.N(N)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign ack_interface2user = grant;

  // Encode the one-hot grant into a port index
  always_comb begin
    sel       = '0;
    any_grant = |grant;
    for (int i = 0; i < int'(N); i++) begin
      if (grant[i]) begin
        sel = PW'(i);
      end
    end
  end

  // Next credit per port: consume on grant, add returns, saturate at the counter max
  always_comb begin
    sum = '0;
    sat = '0;
    for (int i = 0; i < int'(N); i++) begin
      sum = {1'b0, credit[i]} - (CREDIT_BITS+1)'(grant[i]);
      if (credit_vld && (credit_port == NUM_PORT_BITS'(i))) begin
        sum = sum + {1'b0, credit_amount};
      end
      if (sum > CREDIT_MAX) begin
        credit_nxt[i] = CREDIT_MAX[CREDIT_BITS-1:0];
        sat[i]        = 1'b1;
      end else begin
        credit_nxt[i] = sum[CREDIT_BITS-1:0];
      end
    end
  end

  assign bad_return = credit_vld && (32'(credit_port) >= N);

  // Packet register, per-port state, destination table and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_leaf_interface2bft <= '0;
      credit_err              <= 1'b0;
      rr_ptr                  <= '0;
      tbl_vld                 <= '0;
      for (int i = 0; i < int'(N); i++) begin
        credit[i]   <= CREDIT_BITS'(INIT_CREDITS);
        addr[i]     <= '0;
        tbl_leaf[i] <= '0;
        tbl_port[i] <= '0;
      end
    end else begin
      credit_err <= credit_err | (|sat) | bad_return;
      for (int i = 0; i < int'(N); i++) begin
        credit[i] <= credit_nxt[i];
      end
      if (!bft_stall) begin
        dout_leaf_interface2bft <= any_grant
          ? build_packet(1'b1, tbl_leaf[sel], tbl_port[sel], TYPE_DATA, addr[sel], data[sel])
          : '0;
      end
      if (any_grant) begin
        addr[sel] <= addr[sel] + NUM_ADDR_BITS'(1);
        rr_ptr    <= (sel == PW'(N-1)) ? '0 : sel + PW'(1);
      end
      for (int i = 0; i < int'(N); i++) begin
        if (cfg_wr_en && (cfg_port == NUM_PORT_BITS'(i))) begin
          tbl_vld[i]  <= 1'b1;
          tbl_leaf[i] <= cfg_dst_leaf;
          tbl_port[i] <= cfg_dst_port;
        end
      end
    end
  end

endmodule

// File: tb/tb_leaf_stream_packer.sv
// Self-checking bench for leaf_stream_packer: vector table, directed credit/addr/stall/reset sequences, random traffic vs model.
module tb_leaf_stream_packer;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  din;
  logic [1:0]   vld;
  logic [1:0]   ack;
  logic         cfg_wr_en;
  logic [3:0]   cfg_port, cfg_dst_leaf, cfg_dst_port;
  logic         credit_vld;
  logic [3:0]   credit_port;
  logic [7:0]   credit_amount;
  logic         bft_stall;
  logic [48:0]  dout;
  logic         credit_err;

  leaf_stream_packer #(.NUM_OUT_PORTS(2), .INIT_CREDITS(64)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .cfg_wr_en               (cfg_wr_en),
    .cfg_port                (cfg_port),
    .cfg_dst_leaf            (cfg_dst_leaf),
    .cfg_dst_port            (cfg_dst_port),
    .credit_vld              (credit_vld),
    .credit_port             (credit_port),
    .credit_amount           (credit_amount),
    .bft_stall               (bft_stall),
    .dout_leaf_interface2bft (dout),
    .credit_err              (credit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  vld;
    logic        stall;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        cfg_en;
    int          cfg_port;
    int          cfg_leaf;
    int          cfg_dport;
    logic        cv;
    int          crp;
    int          amt;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [1:0]  exp_ack;
    logic [48:0] exp_dout;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_credit [N];
  int          m_addr   [N];
  bit          m_tv     [N];
  int          m_leaf   [N];
  int          m_dport  [N];
  int          m_ptr;
  logic [48:0] m_dout;
  bit          m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [48:0] mk_pkt(input int leaf, input int port, input int a, input logic [31:0] d);
    logic [48:0] p;
    p = {1'b1, 4'(leaf), 4'(port), 1'b1, 7'(a), d};
    return p;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.vld = 2'b00; s.stall = 1'b0; s.d0 = '0; s.d1 = '0;
    s.cfg_en = 1'b0; s.cfg_port = 0; s.cfg_leaf = 0; s.cfg_dport = 0;
    s.cv = 1'b0; s.crp = 0; s.amt = 0;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_credit[i] = 64; m_addr[i] = 0; m_tv[i] = 0; m_leaf[i] = 0; m_dport[i] = 0;
    end
    m_ptr = 0; m_dout = '0; m_err = 0;
  endtask

  // One clock of stimulus: check ack mid-cycle, then dout/credit_err after the edge
  task automatic cycle(input stim_t s, output logic [1:0] ack_seen);
    int         g;
    int         c;
    logic [1:0] eack;
    vld           = s.vld;
    bft_stall     = s.stall;
    din           = {s.d1, s.d0};
    cfg_wr_en     = s.cfg_en;
    cfg_port      = 4'(s.cfg_port);
    cfg_dst_leaf  = 4'(s.cfg_leaf);
    cfg_dst_port  = 4'(s.cfg_dport);
    credit_vld    = s.cv;
    credit_port   = 4'(s.crp);
    credit_amount = 8'(s.amt);
    g = -1;
    if (!s.stall) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && s.vld[i] && m_tv[i] && m_credit[i] > 0) g = i;
      end
    end
    eack = (g >= 0) ? 2'(1 << g) : 2'b00;
    #2;
    check("ack", 64'(ack), 64'(eack));
    ack_seen = ack;
    if (!s.stall) m_dout = (g >= 0) ? mk_pkt(m_leaf[g], m_dport[g], m_addr[g], (g == 0) ? s.d0 : s.d1) : '0;
    for (int i = 0; i < N; i++) begin
      c = m_credit[i] - ((g == i) ? 1 : 0) + ((s.cv && s.crp == i) ? s.amt : 0);
      if (c > 255) begin c = 255; m_err = 1; end
      m_credit[i] = c;
    end
    if (s.cv && s.crp >= N) m_err = 1;
    if (g >= 0) begin
      m_addr[g] = (m_addr[g] + 1) % 128;
      m_ptr     = (g + 1) % N;
    end
    if (s.cfg_en && s.cfg_port < N) begin
      m_tv[s.cfg_port] = 1; m_leaf[s.cfg_port] = s.cfg_leaf; m_dport[s.cfg_port] = s.cfg_dport;
    end
    @(posedge clk); #1;
    check("dout", 64'(dout), 64'(m_dout));
    check("credit_err", 64'(credit_err), 64'(m_err));
  endtask

  vec_t        tbl [17];
  stim_t       s;
  logic [1:0]  a;
  int          cnt;
  int          wraps;
  int          prev_addr;

  initial begin
    reset = 1'b1; vld = '0; din = '0; bft_stall = 0; cfg_wr_en = 0; cfg_port = '0;
    cfg_dst_leaf = '0; cfg_dst_port = '0; credit_vld = 0; credit_port = '0; credit_amount = '0;
    model_reset();

    // Vector table: config, alternation, stall hold, same-cycle table write
    for (int i = 0; i < 17; i++) begin
      tbl[i].s = idle(); tbl[i].exp_ack = 2'b00; tbl[i].exp_dout = '0;
    end
    tbl[0].s.cfg_en = 1; tbl[0].s.cfg_port = 0; tbl[0].s.cfg_leaf = 3; tbl[0].s.cfg_dport = 1;
    tbl[1].s.vld = 2'b01; tbl[1].s.d0 = 32'hDEADBEEF;
    tbl[1].exp_ack = 2'b01; tbl[1].exp_dout = mk_pkt(3, 1, 0, 32'hDEADBEEF);
    tbl[2].s.cfg_en = 1; tbl[2].s.cfg_port = 1; tbl[2].s.cfg_leaf = 5; tbl[2].s.cfg_dport = 2;
    tbl[3].s.vld = 2'b10; tbl[3].s.d1 = 32'h11110000;
    tbl[3].exp_ack = 2'b10; tbl[3].exp_dout = mk_pkt(5, 2, 0, 32'h11110000);
    for (int k = 0; k < 5; k++) begin
      tbl[4+k].s.vld = 2'b11;
      tbl[4+k].s.d0 = 32'hA0000000 + k;
      tbl[4+k].s.d1 = 32'hB0000000 + k;
      tbl[4+k].exp_ack  = (k % 2 == 0) ? 2'b01 : 2'b10;
      tbl[4+k].exp_dout = (k % 2 == 0) ? mk_pkt(3, 1, 1 + k/2, 32'hA0000000 + k)
                                       : mk_pkt(5, 2, 1 + k/2, 32'hB0000000 + k);
    end
    for (int k = 9; k < 12; k++) begin
      tbl[k].s.vld = 2'b11; tbl[k].s.stall = 1; tbl[k].s.d0 = 32'hC0C0C0C0; tbl[k].s.d1 = 32'hC1C1C1C1;
      tbl[k].exp_ack = 2'b00; tbl[k].exp_dout = mk_pkt(3, 1, 3, 32'hA0000004);
    end
    tbl[12].s.vld = 2'b11; tbl[12].s.d0 = 32'hA0000005; tbl[12].s.d1 = 32'hB0000005;
    tbl[12].exp_ack = 2'b10; tbl[12].exp_dout = mk_pkt(5, 2, 3, 32'hB0000005);
    tbl[14].s.vld = 2'b01; tbl[14].s.d0 = 32'hD0D0D0D0;
    tbl[14].s.cfg_en = 1; tbl[14].s.cfg_port = 0; tbl[14].s.cfg_leaf = 7; tbl[14].s.cfg_dport = 4;
    tbl[14].exp_ack = 2'b01; tbl[14].exp_dout = mk_pkt(3, 1, 4, 32'hD0D0D0D0);
    tbl[15].s.vld = 2'b01; tbl[15].s.d0 = 32'hD1D1D1D1;
    tbl[15].exp_ack = 2'b01; tbl[15].exp_dout = mk_pkt(7, 4, 5, 32'hD1D1D1D1);
    tbl[16].s.cfg_en = 1; tbl[16].s.cfg_port = 9; tbl[16].s.cfg_leaf = 1; tbl[16].s.cfg_dport = 1;

    // Reset state, with requests present but no table entries
    vld = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_err", 64'(credit_err), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].s, a);
      check("tbl_ack", 64'(a), 64'(tbl[i].exp_ack));
      check("tbl_dout", 64'(dout), 64'(tbl[i].exp_dout));
    end

    // Drain port 0 credits (58 left), then it must stop with an idle word
    s = idle(); s.vld = 2'b01; s.d0 = 32'h12345678;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      cycle(s, a);
      if (a[0]) cnt++;
      else break;
    end
    check("drain58", 64'(cnt), 64'd58);
    check("empty_dout", 64'(dout), 64'd0);
    s.cv = 1; s.crp = 0; s.amt = 1;
    cycle(s, a);
    check("ret_same_cycle_no_ack", 64'(a), 64'd0);
    s.cv = 0;
    cycle(s, a);
    check("one_credit_ack", 64'(a), 64'd1);
    cycle(s, a);
    check("one_credit_spent", 64'(a), 64'd0);

    // Credit 10, then consume+return 5 in one cycle -> 14 remaining
    s = idle(); s.cv = 1; s.crp = 0; s.amt = 10;
    cycle(s, a);
    s = idle(); s.vld = 2'b01; s.cv = 1; s.crp = 0; s.amt = 5; s.d0 = 32'h55;
    cycle(s, a);
    check("consume_ret_ack", 64'(a), 64'd1);
    s.cv = 0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      cycle(s, a);
      if (a[0]) cnt++;
      else break;
    end
    check("drain14", 64'(cnt), 64'd14);

    // Port 1 streams 130 words with one credit returned each cycle: addr wraps once
    s = idle(); s.vld = 2'b10; s.cv = 1; s.crp = 1; s.amt = 1;
    wraps = 0; prev_addr = -1;
    for (int k = 0; k < 130; k++) begin
      s.d1 = 32'(k);
      cycle(s, a);
      check("wrap_addr", 64'(dout[38:32]), 64'((4 + k) % 128));
      if (prev_addr == 127 && int'(dout[38:32]) == 0) wraps++;
      prev_addr = int'(dout[38:32]);
    end
    check("wrap_count", 64'(wraps), 64'd1);

    // Credit return to nonexistent port sets a sticky error
    check("err_before", 64'(credit_err), 64'd0);
    s = idle(); s.cv = 1; s.crp = 7; s.amt = 3;
    cycle(s, a);
    check("err_set", 64'(credit_err), 64'd1);
    s = idle();
    repeat (3) cycle(s, a);
    check("err_sticky", 64'(credit_err), 64'd1);

    // Async reset with a packet on dout drops it immediately
    s = idle(); s.vld = 2'b10; s.d1 = 32'hFEEDF00D;
    cycle(s, a);
    check("pre_reset_valid", 64'(dout[48]), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("midrst_dout", 64'(dout), 64'd0);
    check("midrst_err", 64'(credit_err), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    s = idle(); s.vld = 2'b11;
    cycle(s, a);

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      s = idle();
      s.vld       = 2'($urandom);
      s.stall     = ($urandom % 8 == 0);
      s.d0        = $urandom;
      s.d1        = $urandom;
      s.cfg_en    = ($urandom % 10 == 0);
      s.cfg_port  = int'($urandom % 4);
      s.cfg_leaf  = int'($urandom % 16);
      s.cfg_dport = int'($urandom % 16);
      s.cv        = ($urandom % 4 == 0);
      s.crp       = int'($urandom % 3);
      s.amt       = ($urandom % 20 == 0) ? 200 : int'($urandom % 4);
      cycle(s, a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
